// File: rtl/activation_pkg.sv
// Shared constants for the piecewise-linear activation pipeline: mode encodings,
// segment thresholds, slopes and intercepts, all expressed in Q.8 units.
package activation_pkg;

  typedef enum logic [1:0] {
    MODE_SIGMOID = 2'd0,
    MODE_TANH    = 2'd1,
    MODE_RELU    = 2'd2,
    MODE_LEAKY   = 2'd3
  } act_mode_e;

  localparam int ONE_Q8 = 256;

  // Sigmoid: four breakpoints, outer segments share one slope.
  localparam int SIG_T0 = -640;
  localparam int SIG_T1 = -256;
  localparam int SIG_T2 = 256;
  localparam int SIG_T3 = 640;
  localparam logic [7:0] SIG_SLOPE_OUTER = 8'd33;
  localparam logic [7:0] SIG_SLOPE_MID   = 8'd59;
  localparam int SIG_B_LO  = 101;
  localparam int SIG_B_MID = 128;
  localparam int SIG_B_HI  = 155;

  localparam int TANH_T0 = -320;
  localparam int TANH_T1 = -128;
  localparam int TANH_T2 = 128;
  localparam int TANH_T3 = 320;
  localparam logic [7:0] TANH_SLOPE_OUTER = 8'd132;
  localparam logic [7:0] TANH_SLOPE_MID   = 8'd236;
  localparam int TANH_B_LO  = -54;
  localparam int TANH_B_MID = 0;
  localparam int TANH_B_HI  = 54;

  localparam int LEAKY_SHIFT = 3;

  // Rescale a Q.8 constant to the sample's fractional width.
  function automatic int scale_q8(input int c, input int frac_w);
    if (frac_w >= 8) return c <<< (frac_w - 8);
    else             return c >>> (8 - frac_w);
  endfunction

endpackage

// File: rtl/pwl_segment_sel.sv
// Per-lane segment lookup: picks slope and intercept for the selected curve and
// produces the direct ReLU / leaky ReLU value.
module pwl_segment_sel
  import activation_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  act_mode_e                 mode,
  input  logic signed [DATA_W-1:0]  x,
  output logic [7:0]                slope,
  output logic signed [DATA_W-1:0]  intercept,
  output logic signed [DATA_W-1:0]  bypass_val
);

  localparam int S_T0 = scale_q8(SIG_T0, FRAC_W);
  localparam int S_T1 = scale_q8(SIG_T1, FRAC_W);
  localparam int S_T2 = scale_q8(SIG_T2, FRAC_W);
  localparam int S_T3 = scale_q8(SIG_T3, FRAC_W);
  localparam int H_T0 = scale_q8(TANH_T0, FRAC_W);
  localparam int H_T1 = scale_q8(TANH_T1, FRAC_W);
  localparam int H_T2 = scale_q8(TANH_T2, FRAC_W);
  localparam int H_T3 = scale_q8(TANH_T3, FRAC_W);

  localparam logic signed [DATA_W-1:0] ONE_V   = DATA_W'(scale_q8(ONE_Q8, FRAC_W));
  localparam logic signed [DATA_W-1:0] M_ONE_V = DATA_W'(scale_q8(-ONE_Q8, FRAC_W));
  localparam logic signed [DATA_W-1:0] S_B_LO  = DATA_W'(scale_q8(SIG_B_LO, FRAC_W));
  localparam logic signed [DATA_W-1:0] S_B_MID = DATA_W'(scale_q8(SIG_B_MID, FRAC_W));
  localparam logic signed [DATA_W-1:0] S_B_HI  = DATA_W'(scale_q8(SIG_B_HI, FRAC_W));
  localparam logic signed [DATA_W-1:0] H_B_LO  = DATA_W'(scale_q8(TANH_B_LO, FRAC_W));
  localparam logic signed [DATA_W-1:0] H_B_MID = DATA_W'(scale_q8(TANH_B_MID, FRAC_W));
  localparam logic signed [DATA_W-1:0] H_B_HI  = DATA_W'(scale_q8(TANH_B_HI, FRAC_W));

  int x_i;
  assign x_i = int'(x);

  // Saturated segments use slope 0 so the multiply-add yields the constant exactly.
  always_comb begin
    slope      = '0;
    intercept  = '0;
    bypass_val = '0;
    case (mode)
      MODE_SIGMOID: begin
        if (x_i < S_T0) begin
          intercept = '0;
        end else if (x_i < S_T1) begin
          slope     = SIG_SLOPE_OUTER;
          intercept = S_B_LO;
        end else if (x_i < S_T2) begin
          slope     = SIG_SLOPE_MID;
          intercept = S_B_MID;
        end else if (x_i < S_T3) begin
          slope     = SIG_SLOPE_OUTER;
          intercept = S_B_HI;
        end else begin
          intercept = ONE_V;
        end
      end
      MODE_TANH: begin
        if (x_i < H_T0) begin
          intercept = M_ONE_V;
        end else if (x_i < H_T1) begin
          slope     = TANH_SLOPE_OUTER;
          intercept = H_B_LO;
        end else if (x_i < H_T2) begin
          slope     = TANH_SLOPE_MID;
          intercept = H_B_MID;
        end else if (x_i < H_T3) begin
          slope     = TANH_SLOPE_OUTER;
          intercept = H_B_HI;
        end else begin
          intercept = ONE_V;
        end
      end
      MODE_RELU:  bypass_val = x[DATA_W-1] ? '0 : x;
      MODE_LEAKY: bypass_val = x[DATA_W-1] ? (x >>> LEAKY_SHIFT) : x;
      default:    bypass_val = '0;
    endcase
  end

endmodule

// File: rtl/activation_pwl_pipe.sv
// Two-stage piecewise-linear activation pipe: S1 holds sample and segment
// coefficients, S2 holds the saturated multiply-add result.
module activation_pwl_pipe
  import activation_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data
);

  localparam int PROD_W = DATA_W + 9;
  localparam int SUM_W  = PROD_W + 1;

  // Handshake: a side transfers when valid && ready at a rising edge; both
  // stages move together whenever the output register is empty or being drained.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  act_mode_e in_mode_e;
  assign in_mode_e = act_mode_e'(in_mode);

  logic signed [DATA_W-1:0] lane_x    [LANES];
  logic [7:0]               sel_slope [LANES];
  logic signed [DATA_W-1:0] sel_icpt  [LANES];
  logic signed [DATA_W-1:0] sel_bval  [LANES];

  logic                     s1_valid_d, s1_valid_q;
  act_mode_e                s1_mode_d,  s1_mode_q;
  logic signed [DATA_W-1:0] s1_x_d     [LANES];
  logic signed [DATA_W-1:0] s1_x_q     [LANES];
  logic [7:0]               s1_slope_d [LANES];
  logic [7:0]               s1_slope_q [LANES];
  logic signed [DATA_W-1:0] s1_icpt_d  [LANES];
  logic signed [DATA_W-1:0] s1_icpt_q  [LANES];
  logic signed [DATA_W-1:0] s1_bval_d  [LANES];
  logic signed [DATA_W-1:0] s1_bval_q  [LANES];

  logic                     s2_valid_d, s2_valid_q;
  logic signed [DATA_W-1:0] s2_y_d [LANES];
  logic signed [DATA_W-1:0] s2_y_q [LANES];

  logic signed [PROD_W-1:0] lane_prod  [LANES];
  logic signed [PROD_W-1:0] lane_shift [LANES];
  logic signed [SUM_W-1:0]  lane_sum   [LANES];
  logic signed [DATA_W-1:0] lane_y     [LANES];

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (&v[SUM_W-1:DATA_W-1] || ~|v[SUM_W-1:DATA_W-1]) return v[DATA_W-1:0];
    else if (v[SUM_W-1])                               return {1'b1, {(DATA_W-1){1'b0}}};
    else                                               return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign lane_x[g] = in_data[g*DATA_W +: DATA_W];

    pwl_segment_sel #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_sel (
      .mode       (in_mode_e),
      .x          (lane_x[g]),
      .slope      (sel_slope[g]),
      .intercept  (sel_icpt[g]),
      .bypass_val (sel_bval[g])
    );

    assign out_data[g*DATA_W +: DATA_W] = s2_y_q[g];
  end

  // Slope is an unsigned Q0.8 fraction; a zero sign bit keeps the product signed.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_prod[i]  = PROD_W'(s1_x_q[i]) * PROD_W'($signed({1'b0, s1_slope_q[i]}));
      lane_shift[i] = lane_prod[i] >>> 8;
      lane_sum[i]   = SUM_W'(lane_shift[i]) + SUM_W'(s1_icpt_q[i]);
      lane_y[i]     = (s1_mode_q == MODE_RELU || s1_mode_q == MODE_LEAKY)
                      ? s1_bval_q[i] : sat(lane_sum[i]);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s2_valid_d = s2_valid_q;
    for (int i = 0; i < LANES; i++) begin
      s1_x_d[i]     = s1_x_q[i];
      s1_slope_d[i] = s1_slope_q[i];
      s1_icpt_d[i]  = s1_icpt_q[i];
      s1_bval_d[i]  = s1_bval_q[i];
      s2_y_d[i]     = s2_y_q[i];
    end
    if (advance) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_mode_d = in_mode_e;
        for (int i = 0; i < LANES; i++) begin
          s1_x_d[i]     = lane_x[i];
          s1_slope_d[i] = sel_slope[i];
          s1_icpt_d[i]  = sel_icpt[i];
          s1_bval_d[i]  = sel_bval[i];
        end
      end
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++) s2_y_d[i] = lane_y[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= MODE_SIGMOID;
      s2_valid_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_x_q[i]     <= '0;
        s1_slope_q[i] <= '0;
        s1_icpt_q[i]  <= '0;
        s1_bval_q[i]  <= '0;
        s2_y_q[i]     <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s2_valid_q <= s2_valid_d;
      for (int i = 0; i < LANES; i++) begin
        s1_x_q[i]     <= s1_x_d[i];
        s1_slope_q[i] <= s1_slope_d[i];
        s1_icpt_q[i]  <= s1_icpt_d[i];
        s1_bval_q[i]  <= s1_bval_d[i];
        s2_y_q[i]     <= s2_y_d[i];
      end
    end
  end

  assign out_valid = s2_valid_q;

endmodule

// File: tb/tb_activation_pwl_pipe.sv
// Directed bench for activation_pwl_pipe: vector table with hand-computed
// results, plus stall, mode-alternation and mid-flight reset sequences.
module tb_activation_pwl_pipe;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int LANES  = 4;
  localparam int W      = LANES * DATA_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_mode = 2'd0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  int stall_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held;
  logic         held_v = 1'b0;

  typedef struct {
    string        name;
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic [W-1:0] exp;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  activation_pwl_pipe #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .LANES  (LANES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [W-1:0] r;
    int v[4];
    v = '{a, b, c, d};
    for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = v[k][DATA_W-1:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enter and leave at posedge+1; the beat is accepted at the edge after in_ready is seen.
  task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic [W-1:0] e);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b expected 1", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, W'(exp_q.size()), W'(0));
  endtask

  // Scoreboard and stall monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h expected no beat", out_data);
      end else begin
        check("beat_data", out_data, exp_q.pop_front());
      end
      rx_cnt++;
    end
    if (rst_n && out_valid && !out_ready) begin
      stall_cnt++;
      check("stall_in_ready", W'(in_ready), W'(0));
      if (held_v) check("stall_hold", out_data, held);
      held   = out_data;
      held_v = 1'b1;
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    int rx0;
    vecs[0] = '{"sig_basic", 2'd0, pack4(0, -512, 256, 1000),      pack4(128, 35, 188, 256)};
    vecs[1] = '{"tanh_basic", 2'd1, pack4(0, 64, -400, 320),       pack4(0, 59, -256, 256)};
    vecs[2] = '{"relu", 2'd2, pack4(-5, 300, 0, -32768),           pack4(0, 300, 0, 0)};
    vecs[3] = '{"leaky", 2'd3, pack4(-80, 7, -1, 0),               pack4(-10, 7, -1, 0)};
    vecs[4] = '{"sig_outer_bnd", 2'd0, pack4(-640, 640, 639, -641), pack4(18, 256, 237, 0)};
    vecs[5] = '{"sig_inner_bnd", 2'd0, pack4(-256, 255, -257, -1), pack4(69, 186, 67, 127)};
    vecs[6] = '{"tanh_bnd", 2'd1, pack4(-320, -128, 128, -129),    pack4(-219, -118, 120, -121)};
    vecs[7] = '{"leaky_edge", 2'd3, pack4(-8, -9, 32767, -32768),  pack4(-1, -2, 32767, -4096)};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_out_data", out_data, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1));

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].mode, vecs[i].data, vecs[i].exp);
      in_valid = 1'b0;
      check($sformatf("%s_lat1", vecs[i].name), W'(out_valid), W'(0));
      @(posedge clk);
      #1;
      check($sformatf("%s_lat2", vecs[i].name), W'(out_valid), W'(1));
      @(posedge clk);
      #1;
    end
    wait_drain("table_drain");

    // Eight-beat stream with the sink stalled for cycles 3-5.
    stall_cnt = 0;
    rx0 = rx_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(vecs[i].mode, vecs[i].data, vecs[i].exp);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12; c++) begin
          out_ready = !(c >= 3 && c <= 5);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain("stream_drain");
    check("stream_count", W'(rx_cnt - rx0), W'(8));
    check("stream_stalls", W'(stall_cnt), W'(3));

    // Back-to-back beats alternating sigmoid and ReLU.
    rx0 = rx_cnt;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send(vecs[0].mode, vecs[0].data, vecs[0].exp);
      else            send(vecs[2].mode, vecs[2].data, vecs[2].exp);
    end
    in_valid = 1'b0;
    wait_drain("alt_drain");
    check("alt_count", W'(rx_cnt - rx0), W'(6));

    // Reset with two beats in flight: nothing may come out afterwards.
    send(vecs[1].mode, vecs[1].data, vecs[1].exp);
    send(vecs[3].mode, vecs[3].data, vecs[3].exp);
    in_valid = 1'b0;
    check("pre_rst_valid", W'(out_valid), W'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", W'(out_valid), W'(0));
    check("async_rst_data", out_data, '0);
    check("async_rst_in_ready", W'(in_ready), W'(1));
    exp_q.delete();
    rx0 = rx_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_stale_beats", W'(rx_cnt - rx0), W'(0));
    check("no_stale_valid", W'(out_valid), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
